// File: rtl/mure_pkg.sv
// Shared trace-encoder types: commit-port entry payload and commit scheduler settings.
package mure_pkg;

   localparam int unsigned ITYPE_LEN = 3;
   localparam int unsigned CAUSE_LEN = 5;
   localparam int unsigned XLEN      = 32;
   localparam int unsigned PRIV_LEN  = 2;

   localparam int unsigned NR_COMMIT_PORTS = 2;
   localparam int unsigned SCHED_DEPTH     = 8;
   localparam int unsigned SCHED_GAP       = 2;

   typedef struct packed {
      logic                 valid;
      logic [ITYPE_LEN-1:0] itype;
      logic [CAUSE_LEN-1:0] cause;
      logic [XLEN-1:0]      tval;
      logic [PRIV_LEN-1:0]  priv;
      logic [XLEN-1:0]      iaddr;
   } fifo_entry_s;

   typedef enum logic {
      ISSUE,
      GAP
   } sched_state_e;

endpackage

// File: rtl/sched_ring_buffer.sv
// Circular entry store with NR_PORTS compacted writes and one pop per cycle.
module sched_ring_buffer
   import mure_pkg::*;
#(
   parameter int unsigned NR_PORTS = 2,
   parameter int unsigned DEPTH    = 8
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        flush_i,
   input  logic        [NR_PORTS-1:0]  we_i,
   input  fifo_entry_s [NR_PORTS-1:0]  wdata_i,
   input  logic                        pop_i,
   output fifo_entry_s                 head_o,
   output logic [$clog2(DEPTH):0]      count_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   fifo_entry_s      mem_q [DEPTH];
   fifo_entry_s      mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;

   // Enabled ports land in consecutive slots, lowest port first.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         for (int unsigned p = 0; p < NR_PORTS; p++) begin
            if (we_i[p]) begin
               mem_d[wr_ptr_d] = wdata_i[p];
               wr_ptr_d        = wr_ptr_d + PW'(1);
               count_d         = count_d + CW'(1);
            end
         end
         if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            count_d  = count_d - CW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload storage needs no reset: count gates every read.
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/commit_scheduler.sv
// Serialises multi-port commit entries onto the single trace-FSM input,
// inserting bubbles after block-closing entries and counting dropped entries.
module commit_scheduler
   import mure_pkg::*;
#(
   parameter int unsigned NR_PORTS   = NR_COMMIT_PORTS,
   parameter int unsigned DEPTH      = SCHED_DEPTH,
   parameter int unsigned GAP_CYCLES = SCHED_GAP,
   parameter int unsigned CNT_LEN    = 16
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  fifo_entry_s [NR_PORTS-1:0]  entry_i,
   input  logic                        flush_i,
   output fifo_entry_s                 entry_o,
   output logic                        full_o,
   output logic                        empty_o,
   output logic                        overflow_o,
   output logic [CNT_LEN-1:0]          dropped_o
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam int unsigned GW = (GAP_CYCLES != 0) ? $clog2(GAP_CYCLES + 1) : 1;

   sched_state_e        state_q, state_d;
   logic [GW-1:0]       gap_cnt_q, gap_cnt_d;
   fifo_entry_s         entry_q, entry_d;
   logic                overflow_q, overflow_d;
   logic [CNT_LEN-1:0]  dropped_q, dropped_d;

   logic [NR_PORTS-1:0] we;
   logic                pop;
   fifo_entry_s         head;
   logic [CW-1:0]       count;
   logic [CW-1:0]       free;
   logic [CW-1:0]       n_acc;

   sched_ring_buffer #(
      .NR_PORTS (NR_PORTS),
      .DEPTH    (DEPTH)
   ) u_buf (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .we_i    (we),
      .wdata_i (entry_i),
      .pop_i   (pop),
      .head_o  (head),
      .count_o (count)
   );

   always_comb begin
      state_d    = state_q;
      gap_cnt_d  = gap_cnt_q;
      entry_d    = '0;
      pop        = 1'b0;
      overflow_d = overflow_q;
      dropped_d  = dropped_q;
      we         = '0;
      n_acc      = '0;

      unique case (state_q)
         ISSUE: begin
            if (count != '0) begin
               pop     = 1'b1;
               entry_d = head;
               if ((head.itype != '0) && (GAP_CYCLES != 0)) begin
                  state_d   = GAP;
                  gap_cnt_d = GW'(GAP_CYCLES);
               end
            end
         end
         GAP: begin
            gap_cnt_d = gap_cnt_q - GW'(1);
            if (gap_cnt_q <= GW'(1)) begin
               state_d = ISSUE;
            end
         end
         default: state_d = ISSUE;
      endcase

      if (flush_i) begin
         pop       = 1'b0;
         entry_d   = '0;
         state_d   = ISSUE;
         gap_cnt_d = '0;
      end

      // A same-cycle pop frees the head slot for an incoming entry.
      free = CW'(DEPTH) - count + CW'(pop);
      for (int unsigned p = 0; p < NR_PORTS; p++) begin
         if (entry_i[p].valid && !flush_i) begin
            if (n_acc < free) begin
               we[p] = 1'b1;
               n_acc = n_acc + CW'(1);
            end else begin
               overflow_d = 1'b1;
               if (dropped_d != '1) begin
                  dropped_d = dropped_d + CNT_LEN'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ISSUE;
         gap_cnt_q  <= '0;
         entry_q    <= '0;
         overflow_q <= 1'b0;
         dropped_q  <= '0;
      end else begin
         state_q    <= state_d;
         gap_cnt_q  <= gap_cnt_d;
         entry_q    <= entry_d;
         overflow_q <= overflow_d;
         dropped_q  <= dropped_d;
      end
   end

   assign entry_o    = entry_q;
   assign overflow_o = overflow_q;
   assign dropped_o  = dropped_q;
   assign full_o     = (CW'(DEPTH) - count) < CW'(NR_PORTS);
   assign empty_o    = (count == '0);

endmodule

// File: tb/tb_commit_scheduler.sv
// Directed bench for commit_scheduler: vector table plus multi-cycle sequences.
module tb_commit_scheduler;
   import mure_pkg::*;

   logic               clk = 1'b0;
   logic               rst_ni = 1'b0;
   logic               flush = 1'b0;
   fifo_entry_s [1:0]  ent_in = '0;
   fifo_entry_s        ent_out;
   logic               full, empty, ovf;
   logic [15:0]        dropped;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   commit_scheduler #(
      .NR_PORTS   (2),
      .DEPTH      (8),
      .GAP_CYCLES (2),
      .CNT_LEN    (16)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_ni),
      .entry_i    (ent_in),
      .flush_i    (flush),
      .entry_o    (ent_out),
      .full_o     (full),
      .empty_o    (empty),
      .overflow_o (ovf),
      .dropped_o  (dropped)
   );

   typedef struct {
      logic        v0;
      logic [2:0]  it0;
      logic [31:0] a0;
      logic        v1;
      logic [2:0]  it1;
      logic [31:0] a1;
      logic        fl;
      logic        ev;
      logic [2:0]  eit;
      logic [31:0] ea;
      logic        ef;
      logic        ee;
      logic        eo;
      logic [15:0] ed;
   } vec_t;

   vec_t tbl[$];

   function automatic fifo_entry_s mk(input logic v, input logic [2:0] it, input logic [31:0] a);
      fifo_entry_s e;
      e = '0;
      if (v) begin
         e.valid = 1'b1;
         e.itype = it;
         e.iaddr = a;
         e.tval  = a ^ 32'h5a5a_0000;
         e.priv  = 2'b11;
         e.cause = a[4:0];
      end
      return e;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic row(input logic v0, input logic [2:0] it0, input logic [31:0] a0,
                      input logic v1, input logic [2:0] it1, input logic [31:0] a1,
                      input logic fl, input logic ev, input logic [2:0] eit, input logic [31:0] ea,
                      input logic ef, input logic ee, input logic eo, input logic [15:0] ed);
      vec_t r;
      r.v0 = v0; r.it0 = it0; r.a0 = a0;
      r.v1 = v1; r.it1 = it1; r.a1 = a1;
      r.fl = fl; r.ev = ev; r.eit = eit; r.ea = ea;
      r.ef = ef; r.ee = ee; r.eo = eo; r.ed = ed;
      tbl.push_back(r);
   endtask

   task automatic drive(input logic v0, input logic [2:0] it0, input logic [31:0] a0,
                        input logic v1, input logic [2:0] it1, input logic [31:0] a1,
                        input logic fl);
      ent_in[0] = mk(v0, it0, a0);
      ent_in[1] = mk(v1, it1, a1);
      flush     = fl;
   endtask

   initial begin
      logic [31:0] got_a[$];
      logic [2:0]  got_it[$];
      int          got_cyc[$];
      logic [31:0] exp_a[$];
      int          cyc;

      // Expected columns describe outputs seen before that row's inputs are applied.
      //   v0 it0 a0        v1 it1 a1        fl  ev eit ea        ef ee eo ed
      row(1, 0, 32'hA0,  1, 0, 32'hB0,  0,  0, 0, 32'h0,   0, 1, 0, 0);
      row(0, 0, 32'h0,   0, 0, 32'h0,   0,  0, 0, 32'h0,   0, 0, 0, 0);
      row(0, 0, 32'h0,   0, 0, 32'h0,   0,  1, 0, 32'hA0,  0, 0, 0, 0);
      row(0, 0, 32'h0,   0, 0, 32'h0,   0,  1, 0, 32'hB0,  0, 1, 0, 0);
      row(1, 2, 32'h50,  1, 0, 32'hC0,  0,  0, 0, 32'h0,   0, 1, 0, 0);
      row(0, 0, 32'h0,   0, 0, 32'h0,   0,  0, 0, 32'h0,   0, 0, 0, 0);
      row(0, 0, 32'h0,   0, 0, 32'h0,   0,  1, 2, 32'h50,  0, 0, 0, 0);
      row(0, 0, 32'h0,   0, 0, 32'h0,   0,  0, 0, 32'h0,   0, 0, 0, 0);
      row(0, 0, 32'h0,   0, 0, 32'h0,   0,  0, 0, 32'h0,   0, 0, 0, 0);
      row(0, 0, 32'h0,   1, 0, 32'hD0,  0,  1, 0, 32'hC0,  0, 1, 0, 0);
      row(0, 0, 32'h0,   0, 0, 32'h0,   0,  0, 0, 32'h0,   0, 0, 0, 0);
      row(1, 0, 32'hE0,  0, 0, 32'h0,   0,  1, 0, 32'hD0,  0, 1, 0, 0);
      row(0, 0, 32'h0,   0, 0, 32'h0,   0,  0, 0, 32'h0,   0, 0, 0, 0);
      row(1, 0, 32'hF1,  1, 0, 32'hF2,  0,  1, 0, 32'hE0,  0, 1, 0, 0);
      row(1, 0, 32'hF3,  1, 0, 32'hF4,  0,  0, 0, 32'h0,   0, 0, 0, 0);
      row(1, 0, 32'hF5,  1, 0, 32'hF6,  0,  1, 0, 32'hF1,  0, 0, 0, 0);
      row(1, 0, 32'hF7,  1, 0, 32'hF8,  0,  1, 0, 32'hF2,  0, 0, 0, 0);
      row(1, 0, 32'h91,  1, 0, 32'h92,  1,  1, 0, 32'hF3,  0, 0, 0, 0);
      row(0, 0, 32'h0,   0, 0, 32'h0,   0,  0, 0, 32'h0,   0, 1, 0, 0);
      row(0, 0, 32'h0,   0, 0, 32'h0,   0,  0, 0, 32'h0,   0, 1, 0, 0);

      repeat (2) @(negedge clk);
      rst_ni = 1'b1;

      foreach (tbl[i]) begin
         chk($sformatf("r%0d.entry", i), 128'(ent_out), 128'(mk(tbl[i].ev, tbl[i].eit, tbl[i].ea)));
         chk($sformatf("r%0d.full", i), 128'(full), 128'(tbl[i].ef));
         chk($sformatf("r%0d.empty", i), 128'(empty), 128'(tbl[i].ee));
         chk($sformatf("r%0d.overflow", i), 128'(ovf), 128'(tbl[i].eo));
         chk($sformatf("r%0d.dropped", i), 128'(dropped), 128'(tbl[i].ed));
         drive(tbl[i].v0, tbl[i].it0, tbl[i].a0, tbl[i].v1, tbl[i].it1, tbl[i].a1, tbl[i].fl);
         @(negedge clk);
      end

      // Fill behind a stream of specials so the head stays blocked in GAP.
      cyc = 0;
      for (int c = 0; c < 7; c++) begin
         if (ent_out.valid) begin
            got_a.push_back(ent_out.iaddr);
            got_it.push_back(ent_out.itype);
            got_cyc.push_back(cyc);
         end
         case (c)
            0: drive(1, 1, 32'h101, 1, 1, 32'h102, 0);
            1: drive(1, 1, 32'h103, 1, 1, 32'h104, 0);
            2: drive(1, 1, 32'h105, 1, 1, 32'h106, 0);
            3: drive(1, 1, 32'h107, 0, 0, 32'h0, 0);
            4: drive(1, 1, 32'h108, 1, 1, 32'h109, 0);
            5: begin
               chk("fill.full_at_7", 128'(full), 128'(1));
               chk("fill.ovf_before", 128'(ovf), 128'(0));
               chk("fill.drop_before", 128'(dropped), 128'(0));
               drive(1, 1, 32'h111, 1, 1, 32'h112, 0);
            end
            default: begin
               chk("fill.full_at_8", 128'(full), 128'(1));
               chk("fill.ovf_after", 128'(ovf), 128'(1));
               chk("fill.drop_after", 128'(dropped), 128'(1));
               drive(0, 0, 32'h0, 0, 0, 32'h0, 0);
            end
         endcase
         @(negedge clk);
         cyc++;
      end
      for (int c = 0; c < 40; c++) begin
         if (ent_out.valid) begin
            got_a.push_back(ent_out.iaddr);
            got_it.push_back(ent_out.itype);
            got_cyc.push_back(cyc);
         end
         @(negedge clk);
         cyc++;
      end
      for (int k = 1; k <= 9; k++) exp_a.push_back(32'h100 + 32'(k));
      exp_a.push_back(32'h111);
      chk("fill.count", 128'(got_a.size()), 128'(exp_a.size()));
      foreach (exp_a[k]) begin
         if (k < got_a.size()) begin
            chk($sformatf("fill.order%0d", k), 128'(got_a[k]), 128'(exp_a[k]));
            chk($sformatf("fill.itype%0d", k), 128'(got_it[k]), 128'(1));
            if (k > 0) chk($sformatf("fill.spacing%0d", k), 128'(got_cyc[k] - got_cyc[k-1]), 128'(3));
         end
      end
      chk("fill.empty_end", 128'(empty), 128'(1));
      chk("fill.ovf_sticky", 128'(ovf), 128'(1));

      // Flush with entries buffered and a same-cycle push: counters must survive.
      drive(1, 0, 32'h301, 1, 0, 32'h302, 0);
      @(negedge clk);
      drive(1, 0, 32'h303, 1, 0, 32'h304, 1);
      @(negedge clk);
      drive(0, 0, 32'h0, 0, 0, 32'h0, 0);
      chk("flush2.entry", 128'(ent_out), 128'(mk(0, 0, 0)));
      chk("flush2.empty", 128'(empty), 128'(1));
      chk("flush2.dropped", 128'(dropped), 128'(1));
      chk("flush2.ovf", 128'(ovf), 128'(1));
      @(negedge clk);
      chk("flush2.still_empty", 128'(ent_out), 128'(mk(0, 0, 0)));

      // Twenty single entries, alternating ports, through both pointer wraps.
      for (int k = 0; k < 22; k++) begin
         if (k >= 2) chk($sformatf("stream%0d", k - 2), 128'(ent_out), 128'(mk(1, 0, 32'h200 + 32'(k - 2))));
         else        chk($sformatf("stream_lead%0d", k), 128'(ent_out), 128'(mk(0, 0, 0)));
         chk($sformatf("stream_cnt%0d", k), 128'(dut.u_buf.count_q <= 4'd1), 128'(1));
         if (k < 20) begin
            if (k % 2 == 0) drive(1, 0, 32'h200 + 32'(k), 0, 0, 32'h0, 0);
            else            drive(0, 0, 32'h0, 1, 0, 32'h200 + 32'(k), 0);
         end else begin
            drive(0, 0, 32'h0, 0, 0, 32'h0, 0);
         end
         @(negedge clk);
      end

      // Asynchronous reset in the middle of a stream.
      drive(1, 0, 32'h401, 1, 0, 32'h402, 0);
      @(negedge clk);
      drive(1, 0, 32'h403, 1, 0, 32'h404, 0);
      @(negedge clk);
      drive(0, 0, 32'h0, 0, 0, 32'h0, 0);
      chk("rst.pre_entry", 128'(ent_out), 128'(mk(1, 0, 32'h401)));
      #2 rst_ni = 1'b0;
      #1;
      chk("rst.entry", 128'(ent_out), 128'(mk(0, 0, 0)));
      chk("rst.full", 128'(full), 128'(0));
      chk("rst.empty", 128'(empty), 128'(1));
      chk("rst.ovf", 128'(ovf), 128'(0));
      chk("rst.dropped", 128'(dropped), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
